// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_scan display driver.
// Holds the active-high abcdefg segment patterns for the sixteen hex glyphs,
// the all-off pattern, and a constant ceil(log2) helper used to size the
// prescaler and digit-index counters.
package seg7_pkg;

    // Segment patterns, bit 6 = a ... bit 0 = g, 1 = segment lit.
    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex-to-seven-segment decoder.
// Ports:
//   nib_i  - 4-bit hex digit
//   seg_o  - active-high segment pattern, seg_o[6] = a ... seg_o[0] = g
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Glyph lookup for the sixteen hex digits.
    always_comb begin
        seg_o = SEG_OFF;
        case (nib_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for an NDIG-digit common-anode seven-segment display.
// A prescaler divides the clock into digit slots of SCAN_DIV cycles; each slot
// opens with BLANK_CYC cycles of all anodes off to suppress ghosting. Loads go
// to a pending shadow and are copied to the displayed (active) copy only at the
// frame boundary, so a frame never mixes old and new digits.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   value_i       - packed nibbles, digit 0 (rightmost) in value_i[3:0]
//   dp_i          - decimal point per digit
//   digit_en_i    - per-digit enable, 0 force-blanks the digit
//   blank_lz_i    - leading-zero blanking enable (used live, not shadowed)
//   load_i        - one-cycle strobe capturing value_i, dp_i, digit_en_i
//   seg_o         - segment pins a..g (bit 6 = a)
//   dp_out_o      - decimal point pin
//   an_o          - anode pins, at most one active
//   frame_done_o  - one-cycle pulse after the last slot of a frame ends
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NDIG           = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYC      = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4*NDIG-1:0] value_i,
    input  logic [NDIG-1:0]   dp_i,
    input  logic [NDIG-1:0]   digit_en_i,
    input  logic              blank_lz_i,
    input  logic              load_i,
    output logic [6:0]        seg_o,
    output logic              dp_out_o,
    output logic [NDIG-1:0]   an_o,
    output logic              frame_done_o
);

    localparam int PC_W  = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
    localparam int IDX_W = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

    localparam logic [PC_W-1:0]  PC_MAX   = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0]  PC_BLANK = PC_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NDIG - 1);

    // Pin-level "everything off" values.
    localparam logic [6:0]      SEG_PIN_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic            DP_PIN_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NDIG-1:0] AN_PIN_OFF  = (AN_ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    logic [PC_W-1:0]   pc_q,  pc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] val_pend_q, val_pend_d, val_act_q, val_act_d;
    logic [NDIG-1:0]   dp_pend_q, dp_pend_d, dp_act_q, dp_act_d;
    logic [NDIG-1:0]   en_pend_q, en_pend_d, en_act_q, en_act_d;

    logic [6:0]        seg_q, seg_d;
    logic              dp_out_q, dp_out_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              frame_done_q, frame_done_d;

    logic              slot_end_s, frame_end_s;
    logic [3:0]        nib_s;
    logic [6:0]        seg_raw_s;
    logic              lz_s;

    assign slot_end_s  = (pc_q == PC_MAX);
    assign frame_end_s = slot_end_s && (idx_q == IDX_MAX);
    assign nib_s       = val_act_q[{idx_q, 2'b00} +: 4];

    seg7_hex_dec u_dec (
        .nib_i (nib_s),
        .seg_o (seg_raw_s)
    );

    // Scan counters and pending/active shadow transfer.
    always_comb begin
        pc_d       = pc_q;
        idx_d      = idx_q;
        val_pend_d = val_pend_q;
        dp_pend_d  = dp_pend_q;
        en_pend_d  = en_pend_q;
        val_act_d  = val_act_q;
        dp_act_d   = dp_act_q;
        en_act_d   = en_act_q;

        if (slot_end_s) begin
            pc_d  = {PC_W{1'b0}};
            idx_d = (idx_q == IDX_MAX) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
        end else begin
            pc_d  = pc_q + PC_W'(1);
            idx_d = idx_q;
        end

        if (load_i) begin
            val_pend_d = value_i;
            dp_pend_d  = dp_i;
            en_pend_d  = digit_en_i;
        end else begin
            val_pend_d = val_pend_q;
            dp_pend_d  = dp_pend_q;
            en_pend_d  = en_pend_q;
        end

        // A load landing on the boundary bypasses the shadow so it shows next slot.
        if (frame_end_s) begin
            val_act_d = val_pend_d;
            dp_act_d  = dp_pend_d;
            en_act_d  = en_pend_d;
        end else begin
            val_act_d = val_act_q;
            dp_act_d  = dp_act_q;
            en_act_d  = en_act_q;
        end
    end

    // Blanking, anode select and pin polarity ahead of the output registers.
    always_comb begin
        seg_d        = SEG_OFF;
        dp_out_d     = 1'b0;
        an_d         = {NDIG{1'b0}};
        frame_done_d = frame_end_s;

        // Blank when this digit and everything above it is zero (never digit 0).
        lz_s = blank_lz_i && (idx_q != {IDX_W{1'b0}}) &&
               ((val_act_q >> {idx_q, 2'b00}) == {(4*NDIG){1'b0}});

        if (en_act_q[idx_q] && !lz_s) begin
            seg_d = seg_raw_s;
        end else begin
            seg_d = SEG_OFF;
        end

        if (en_act_q[idx_q]) begin
            dp_out_d = dp_act_q[idx_q];
        end else begin
            dp_out_d = 1'b0;
        end

        for (int i = 0; i < NDIG; i++) begin
            an_d[i] = (pc_q >= PC_BLANK) && (idx_q == IDX_W'(i));
        end

        if (SEG_ACTIVE_LOW != 0) begin
            seg_d    = ~seg_d;
            dp_out_d = ~dp_out_d;
        end else begin
            seg_d    = seg_d;
            dp_out_d = dp_out_d;
        end

        if (AN_ACTIVE_LOW != 0) begin
            an_d = ~an_d;
        end else begin
            an_d = an_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= {PC_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            val_pend_q   <= {(4*NDIG){1'b0}};
            dp_pend_q    <= {NDIG{1'b0}};
            en_pend_q    <= {NDIG{1'b0}};
            val_act_q    <= {(4*NDIG){1'b0}};
            dp_act_q     <= {NDIG{1'b0}};
            en_act_q     <= {NDIG{1'b0}};
            seg_q        <= SEG_PIN_OFF;
            dp_out_q     <= DP_PIN_OFF;
            an_q         <= AN_PIN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            val_pend_q   <= val_pend_d;
            dp_pend_q    <= dp_pend_d;
            en_pend_q    <= en_pend_d;
            val_act_q    <= val_act_d;
            dp_act_q     <= dp_act_d;
            en_act_q     <= en_act_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_o        = seg_q;
    assign dp_out_o     = dp_out_q;
    assign an_o         = an_q;
    assign frame_done_o = frame_done_q;

endmodule
